// File: rtl/axi_pkg.sv
// Shared AXI4 encodings: burst types and response codes.
package axi_pkg;

   typedef enum logic [1:0] {
      FIXED = 2'd0,
      INCR  = 2'd1,
      WRAP  = 2'd2
   } burst_t;

   localparam logic [1:0] OKAY   = 2'd0;
   localparam logic [1:0] SLVERR = 2'd2;

endpackage

// File: rtl/axi_channel.sv
// AXI4 channel bundle with initiator and responder views; clk/rstn are carried for other users.
interface axi_channel #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input logic clk,
   input logic rstn
);
   logic                    aw_valid, aw_ready;
   logic [ID_WIDTH-1:0]     aw_id;
   logic [ADDR_WIDTH-1:0]   aw_addr;
   logic [7:0]              aw_len;
   logic [2:0]              aw_size;
   logic [1:0]              aw_burst;
   logic                    w_valid, w_ready, w_last;
   logic [DATA_WIDTH-1:0]   w_data;
   logic [DATA_WIDTH/8-1:0] w_strb;
   logic                    b_valid, b_ready;
   logic [ID_WIDTH-1:0]     b_id;
   logic [1:0]              b_resp;
   logic                    ar_valid, ar_ready;
   logic [ID_WIDTH-1:0]     ar_id;
   logic [ADDR_WIDTH-1:0]   ar_addr;
   logic [7:0]              ar_len;
   logic [2:0]              ar_size;
   logic [1:0]              ar_burst;
   logic                    r_valid, r_ready, r_last;
   logic [ID_WIDTH-1:0]     r_id;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [1:0]              r_resp;

   modport master (
      input  clk, rstn,
      output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, input aw_ready,
      output w_valid, w_data, w_strb, w_last, input w_ready,
      input  b_valid, b_id, b_resp, output b_ready,
      output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, input ar_ready,
      input  r_valid, r_id, r_data, r_resp, r_last, output r_ready
   );

   modport slave (
      input  clk, rstn,
      input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, output aw_ready,
      input  w_valid, w_data, w_strb, w_last, output w_ready,
      output b_valid, b_id, b_resp, input b_ready,
      input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, output ar_ready,
      output r_valid, r_id, r_data, r_resp, r_last, input r_ready
   );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Next beat byte address for FIXED / INCR / WRAP bursts.
module axi_burst_addr_gen
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [7:0]            len,
   input  logic [2:0]            size,
   input  logic [1:0]            burst,
   output logic [ADDR_WIDTH-1:0] next_addr
);
   logic [ADDR_WIDTH-1:0] step, incr, wrap_mask;

   always_comb begin
      step      = ADDR_WIDTH'(1) << size;
      incr      = addr + step;
      // Window is (len+1) beats of 2^size bytes, a power of two for any legal WRAP.
      wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
      case (burst_t'(burst))
         FIXED:   next_addr = addr;
         WRAP:    next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
         default: next_addr = incr;
      endcase
   end
endmodule

// File: rtl/axi_to_ram.sv
// AXI4 responder onto a single-port synchronous RAM, one burst at a time.
// Define AXI_TO_RAM_BOUNDS_CHECK_EN to reject beats beyond the RAM with SLVERR.
module axi_to_ram
   import axi_pkg::*;
#(
   parameter int RAM_ADDR_WIDTH = 10
) (
   input  logic                              clk,
   input  logic                              rst,
   axi_channel.slave                         master,
   output logic                              ram_req,
   output logic                              ram_we,
   output logic [RAM_ADDR_WIDTH-1:0]         ram_addr,
   output logic [$bits(master.w_data)/8-1:0] ram_wmask,
   output logic [$bits(master.w_data)-1:0]   ram_wdata,
   input  logic [$bits(master.w_data)-1:0]   ram_rdata
);
   localparam int DW  = $bits(master.w_data);
   localparam int AW  = $bits(master.aw_addr);
   localparam int IW  = $bits(master.aw_id);
   localparam int LSB = $clog2(DW / 8);

   typedef enum logic [1:0] {IDLE, WRITE, WRITE_RESP, READ} state_t;

   state_t          state;
   logic            last_read, wr_err, b_valid_q, iss_done;
   logic [AW-1:0]   cur_addr, next_addr;
   logic [7:0]      len_q, cnt;
   logic [2:0]      size_q;
   logic [1:0]      burst_q;
   logic [IW-1:0]   id_q;
   logic            live, oob, aw_hs, ar_hs, w_beat, issue, r_hs, push, pop;
   // Read return path: one beat in flight from the RAM plus a 2-deep skid buffer.
   logic            infl, infl_last, infl_err;
   logic [1:0]      rcount;
   logic [DW-1:0]   buf_data [2];
   logic [1:0]      buf_last, buf_err;
   logic [DW-1:0]   in_data, out_data;
   logic            out_last, out_err;

   function automatic logic [AW-1:0] align(input logic [AW-1:0] a, input logic [2:0] s);
      return a & ~((AW'(1) << s) - AW'(1));
   endfunction

   axi_burst_addr_gen #(.ADDR_WIDTH(AW)) u_addr_gen (
      .addr(cur_addr), .len(len_q), .size(size_q), .burst(burst_q), .next_addr(next_addr)
   );

`ifdef AXI_TO_RAM_BOUNDS_CHECK_EN
   assign oob = |(cur_addr >> (RAM_ADDR_WIDTH + LSB));
`else
   assign oob = 1'b0;
`endif

   assign live            = !rst;
   assign master.aw_ready = live && state == IDLE && master.aw_valid && (!master.ar_valid || last_read);
   assign master.ar_ready = live && state == IDLE && master.ar_valid && (!master.aw_valid || !last_read);
   assign master.w_ready  = live && state == WRITE;
   assign aw_hs           = master.aw_valid && master.aw_ready;
   assign ar_hs           = master.ar_valid && master.ar_ready;
   assign w_beat          = master.w_valid && master.w_ready;
   assign issue           = live && state == READ && !iss_done && (rcount == 2'd0 || (rcount == 2'd1 && !infl));

   assign ram_req   = (w_beat || issue) && !oob;
   assign ram_we    = w_beat;
   assign ram_addr  = cur_addr[RAM_ADDR_WIDTH+LSB-1:LSB];
   assign ram_wmask = master.w_strb;
   assign ram_wdata = master.w_data;

   assign master.b_valid = live && b_valid_q;
   assign master.b_id    = id_q;
   assign master.b_resp  = wr_err ? SLVERR : OKAY;

   always_comb begin
      in_data = infl_err ? '0 : ram_rdata;
      if (rcount != 2'd0) begin
         out_data = buf_data[0];
         out_last = buf_last[0];
         out_err  = buf_err[0];
      end else begin
         out_data = in_data;
         out_last = infl_last;
         out_err  = infl_err;
      end
   end

   assign master.r_valid = live && (rcount != 2'd0 || infl);
   assign master.r_data  = out_data;
   assign master.r_last  = out_last;
   assign master.r_resp  = out_err ? SLVERR : OKAY;
   assign master.r_id    = id_q;
   assign r_hs           = master.r_valid && master.r_ready;
   assign push           = infl && !(rcount == 2'd0 && r_hs);
   assign pop            = r_hs && rcount != 2'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last_read <= 1'b1;
         cnt       <= '0;
         wr_err    <= 1'b0;
         b_valid_q <= 1'b0;
         iss_done  <= 1'b0;
         infl      <= 1'b0;
         rcount    <= '0;
      end else begin
         infl   <= issue;
         rcount <= rcount + {1'b0, push} - {1'b0, pop};
         case (state)
            IDLE: begin
               if (aw_hs) begin
                  id_q <= master.aw_id; cur_addr <= align(master.aw_addr, master.aw_size);
                  len_q <= master.aw_len; size_q <= master.aw_size; burst_q <= master.aw_burst;
                  cnt <= '0; wr_err <= 1'b0; last_read <= 1'b0; state <= WRITE;
               end else if (ar_hs) begin
                  id_q <= master.ar_id; cur_addr <= align(master.ar_addr, master.ar_size);
                  len_q <= master.ar_len; size_q <= master.ar_size; burst_q <= master.ar_burst;
                  cnt <= '0; iss_done <= 1'b0; last_read <= 1'b1; state <= READ;
               end
            end
            WRITE: begin
               if (w_beat) begin
                  cur_addr <= next_addr;
                  cnt      <= cnt + 8'd1;
                  wr_err   <= wr_err | oob;
                  if (cnt == len_q) begin
                     b_valid_q <= 1'b1;
                     state     <= WRITE_RESP;
                  end
               end
            end
            WRITE_RESP: begin
               if (master.b_ready) begin
                  b_valid_q <= 1'b0;
                  state     <= IDLE;
               end
            end
            READ: begin
               if (issue) begin
                  cur_addr <= next_addr;
                  cnt      <= cnt + 8'd1;
                  if (cnt == len_q) iss_done <= 1'b1;
               end
               if (r_hs && out_last) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      infl_last <= (cnt == len_q);
      infl_err  <= oob;
      if (pop) begin
         buf_data[0] <= buf_data[1];
         buf_last[0] <= buf_last[1];
         buf_err[0]  <= buf_err[1];
      end
      if (push) begin
         if (rcount == 2'd0 || (rcount == 2'd1 && pop)) begin
            buf_data[0] <= in_data; buf_last[0] <= infl_last; buf_err[0] <= infl_err;
         end else begin
            buf_data[1] <= in_data; buf_last[1] <= infl_last; buf_err[1] <= infl_err;
         end
      end
   end
endmodule
